// File: rtl/slos_seq_pkg.sv
// Shared types and constants for the SLOS1/SLOS2 sequencer.
package slos_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SLOS1 = 3'd1,
        ST_SLOS2 = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic GEN_SEL_SLOS1 = 1'b0;
    localparam logic GEN_SEL_SLOS2 = 1'b1;

endpackage

// File: rtl/slos_seq_timer.sv
// Per-phase cycle timer; expired flags the last cycle of the phase budget.
module slos_seq_timer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TMO_W          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/slos_sequencer.sv
// Sequences the lane SLOS generator through SLOS1 then SLOS2, gated on peer detect.
//
// state | meaning
// IDLE  | generator off, waiting for start
// SLOS1 | sending SLOS1 rounds until count and peer SLOS1 detect are met
// SLOS2 | sending SLOS2 rounds until count and peer SLOS2 detect are met
// DONE  | one-cycle completion pulse
// ERROR | phase budget ran out; waits for start or abort
module slos_sequencer
    import slos_seq_pkg::*;
#(
    parameter int N_SLOS1        = 2,
    parameter int N_SLOS2        = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 8,
    parameter int TMO_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       peer_slos1_det,
    input  logic       peer_slos2_det,
    input  logic       slos_sent,
    output logic       gen_enable,
    output logic       gen_sel,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [2:0] state_out
);

    localparam logic [CNT_W:0] N1 = (CNT_W + 1)'(N_SLOS1);
    localparam logic [CNT_W:0] N2 = (CNT_W + 1)'(N_SLOS2);

    state_t           state;
    logic [CNT_W-1:0] round_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   need;
    logic [CNT_W-1:0] cnt_sat;
    logic             in_phase;
    logic             peer_det;
    logic             phase_exit;
    logic             tmr_clear;
    logic             tmr_expired;

    always_comb begin
        in_phase   = (state == ST_SLOS1) || (state == ST_SLOS2);
        cnt_inc    = {1'b0, round_cnt} + (CNT_W + 1)'(1);
        need       = (state == ST_SLOS2) ? N2 : N1;
        peer_det   = (state == ST_SLOS2) ? peer_slos2_det : peer_slos1_det;
        cnt_sat    = (cnt_inc >= need) ? need[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
        phase_exit = in_phase && slos_sent && (cnt_inc >= need) && peer_det;
        tmr_clear  = !in_phase || phase_exit || tmr_expired || abort;
    end

    slos_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .run    (in_phase),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            round_cnt   <= '0;
            gen_enable  <= 1'b0;
            gen_sel     <= GEN_SEL_SLOS1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                round_cnt   <= '0;
                gen_enable  <= 1'b0;
                gen_sel     <= GEN_SEL_SLOS1;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        round_cnt  <= '0;
                        gen_sel    <= GEN_SEL_SLOS1;
                        gen_enable <= start;
                        if (start) state <= ST_SLOS1;
                    end
                    ST_SLOS1, ST_SLOS2: begin
                        // a qualifying round wins over a timeout in the same cycle
                        if (phase_exit) begin
                            round_cnt <= '0;
                            if (state == ST_SLOS1) begin
                                state   <= ST_SLOS2;
                                gen_sel <= GEN_SEL_SLOS2;
                            end else begin
                                state      <= ST_DONE;
                                done       <= 1'b1;
                                gen_enable <= 1'b0;
                                gen_sel    <= GEN_SEL_SLOS1;
                            end
                        end else if (tmr_expired) begin
                            state       <= ST_ERROR;
                            round_cnt   <= '0;
                            gen_enable  <= 1'b0;
                            gen_sel     <= GEN_SEL_SLOS1;
                            timeout_err <= 1'b1;
                        end else if (slos_sent) begin
                            round_cnt <= cnt_sat;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    ST_ERROR: begin
                        if (start) begin
                            state       <= ST_SLOS1;
                            round_cnt   <= '0;
                            gen_enable  <= 1'b1;
                            gen_sel     <= GEN_SEL_SLOS1;
                            timeout_err <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        round_cnt   <= '0;
                        gen_enable  <= 1'b0;
                        gen_sel     <= GEN_SEL_SLOS1;
                        timeout_err <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = in_phase;
    assign state_out = state;

endmodule

// File: tb/tb_slos_sequencer.sv
// Self-checking bench for slos_sequencer: default instance plus a short-timeout instance.
module tb_slos_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic peer1 = 1'b1;
    logic peer2 = 1'b1;
    logic sent_a = 1'b0;
    logic sent_b = 1'b0;

    logic       en_a, sel_a, busy_a, done_a, err_a;
    logic       en_b, sel_b, busy_b, done_b, err_b;
    logic [2:0] st_a, st_b;
    logic [7:0] obs_a, obs_b, obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        bit         on_b;
        logic [7:0] v;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    slos_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .peer_slos1_det(peer1), .peer_slos2_det(peer2), .slos_sent(sent_a),
        .gen_enable(en_a), .gen_sel(sel_a), .busy(busy_a), .done(done_a),
        .timeout_err(err_a), .state_out(st_a)
    );

    slos_sequencer #(.TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .peer_slos1_det(peer1), .peer_slos2_det(peer2), .slos_sent(sent_b),
        .gen_enable(en_b), .gen_sel(sel_b), .busy(busy_b), .done(done_b),
        .timeout_err(err_b), .state_out(st_b)
    );

    assign obs_a = {st_a, en_a, sel_a, busy_a, done_a, err_a};
    assign obs_b = {st_b, en_b, sel_b, busy_b, done_b, err_b};

    // expected {state, gen_enable, gen_sel, busy, done, timeout_err} for a settled state
    function automatic logic [7:0] model(input logic [2:0] st);
        case (st)
            3'd1:    return {3'd1, 5'b10100};
            3'd2:    return {3'd2, 5'b11100};
            3'd3:    return {3'd3, 5'b00010};
            3'd4:    return {3'd4, 5'b00001};
            default: return {3'd0, 5'b00000};
        endcase
    endfunction

    task automatic sb_push(input string name, input bit on_b, input logic [2:0] st);
        sbq.push_back('{name, on_b, model(st)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap, input bit to_b);
        repeat (gap - 1) tick();
        if (to_b) sent_b = 1'b1;
        else sent_a = 1'b1;
        tick();
        sent_a = 1'b0;
        sent_b = 1'b0;
    endtask

    task automatic normalize();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        peer1 = 1'b1;
        peer2 = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        sb_push("reset_a", 1'b0, 3'd0);
        sb_push("reset_b", 1'b1, 3'd0);
        repeat (2) begin
            e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        normalize();
        sb_push("nom_start", 1'b0, 3'd1);
        do_start();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        for (int i = 1; i <= 4; i++) begin
            sb_push($sformatf("nom_pulse%0d", i), 1'b0, (i < 2) ? 3'd1 : ((i < 4) ? 3'd2 : 3'd3));
            pulse(2048, 1'b0);
            e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        end
        sb_push("nom_idle", 1'b0, 3'd0);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
    endtask

    task automatic test_late_peer();
        normalize();
        peer1 = 1'b0;
        do_start();
        for (int i = 1; i <= 8; i++) begin
            if (i == 6) peer1 = 1'b1;
            sb_push($sformatf("late_pulse%0d", i), 1'b0, (i < 6) ? 3'd1 : ((i < 8) ? 3'd2 : 3'd3));
            pulse(64, 1'b0);
            e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        end
        tick();
    endtask

    task automatic test_timeout();
        normalize();
        sb_push("tmo_enter", 1'b1, 3'd1);
        do_start();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        repeat (98) tick();
        sb_push("tmo_cycle99", 1'b1, 3'd1);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        sb_push("tmo_error", 1'b1, 3'd4);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        sb_push("tmo_hold", 1'b1, 3'd4);
        repeat (3) tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        sb_push("tmo_restart", 1'b1, 3'd1);
        do_start();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
    endtask

    task automatic test_collisions();
        // abort coinciding with the final qualifying SLOS2 round
        normalize();
        do_start();
        pulse(16, 1'b0);
        sb_push("coll_slos2", 1'b0, 3'd2);
        pulse(16, 1'b0);
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        pulse(16, 1'b0);
        sb_push("coll_abort", 1'b0, 3'd0);
        sb_push("coll_nodone", 1'b0, 3'd0);
        repeat (15) tick();
        sent_a = 1'b1;
        abort  = 1'b1;
        tick();
        sent_a = 1'b0;
        abort  = 1'b0;
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end

        // qualifying SLOS1 round lands on the timer's last cycle
        normalize();
        do_start();
        pulse(10, 1'b1);
        sb_push("coll_tmo_exit", 1'b1, 3'd2);
        pulse(90, 1'b1);
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        sb_push("coll_tmo_stay", 1'b1, 3'd2);
        repeat (5) tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
    endtask

    task automatic test_reset_mid();
        normalize();
        do_start();
        pulse(16, 1'b0);
        pulse(16, 1'b0);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        sb_push("rst_async_a", 1'b0, 3'd0);
        sb_push("rst_async_b", 1'b1, 3'd0);
        repeat (2) begin
            e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        end
        #2 reset = 1'b0;
        sb_push("rst_idle", 1'b0, 3'd0);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
    endtask

    task automatic test_start_mid();
        normalize();
        do_start();
        pulse(20, 1'b0);
        repeat (29) tick();
        sb_push("mid_start_a", 1'b0, 3'd1);
        sb_push("mid_start_b", 1'b1, 3'd1);
        do_start();
        repeat (2) begin
            e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        end
        sb_push("mid_cnt_kept", 1'b0, 3'd2);
        pulse(10, 1'b0);
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        repeat (38) tick();
        sb_push("mid_tmr_99", 1'b1, 3'd1);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        sb_push("mid_tmr_kept", 1'b1, 3'd4);
        tick();
        e = sbq.pop_front(); obs = e.on_b ? obs_b : obs_a; n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b, want %b", e.name, obs, e.v); end
        normalize();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_late_peer();
        test_timeout();
        test_collisions();
        test_reset_mid();
        test_start_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slos_sequencer.md
# slos_sequencer

Controller that sequences the lane's SLOS pattern generator through the SLOS1 → SLOS2 phases of lane initialization. It drives the generator's enable and pattern-select inputs and counts completed SLOS rounds from the generator's `slos_sent` pulse. It gates phase changes on peer-detection inputs from the receive side, and it reports completion or timeout to the lane-training FSM above it. It sits between the lane-training FSM and one `slos_send` instance per lane.

## Interface
Parameters:
- `N_SLOS1`, default 2: minimum SLOS1 rounds sent before SLOS2 is allowed (≥1).
- `N_SLOS2`, default 2: minimum SLOS2 rounds sent before completion (≥1).
- `TIMEOUT_CYCLES`, default 65535: cycle budget per phase (≥2).
- `CNT_W`, default 8: round-counter width; must hold max(N_SLOS1, N_SLOS2).
- `TMO_W`, default 16: timer width; must hold TIMEOUT_CYCLES.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin sequence; sampled only in IDLE or ERROR.
- `abort` in 1: return to IDLE from any state.
- `peer_slos1_det` in 1: level; the peer's SLOS1 is being received.
- `peer_slos2_det` in 1: level; the peer's SLOS2 is being received.
- `slos_sent` in 1: one-cycle pulse from the generator per completed round.
- `gen_enable` out 1: registered; drives the generator's `enable`.
- `gen_sel` out 1: registered; drives the generator's `slos1_slos2`. 0 selects SLOS1, 1 selects SLOS2.
- `busy` out 1: high in SLOS1 or SLOS2 (decoded from the state register).
- `done` out 1: one-cycle pulse on successful completion.
- `timeout_err` out 1: sticky; high while in ERROR.
- `state_out` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, SLOS1=1, SLOS2=2, DONE=3, ERROR=4. Encodings 5–7 are illegal and go to IDLE on the next edge.
- IDLE:
  - `gen_enable`=0, `gen_sel`=0, round counter and timer cleared.
  - `start`=1 and `abort`=0 → SLOS1.
- SLOS1:
  - `gen_enable`=1, `gen_sel`=0.
  - Each `slos_sent` pulse increments the round counter, saturating at N_SLOS1.
  - Exit to SLOS2 requires `slos_sent`=1, counter+1 ≥ N_SLOS1 and `peer_slos1_det`=1, all in the same cycle.
  - On exit, the counter and timer clear and `gen_sel` becomes 1.
  - `gen_enable` stays 1 across the phase change, so the generator never reloads its seed mid-sequence.
- SLOS2:
  - Same rules, using N_SLOS2 and `peer_slos2_det`.
  - Exit goes to DONE.
- DONE: lasts one cycle. `done`=1, `gen_enable`=0, `gen_sel`=0. Next state is IDLE.
- ERROR:
  - `gen_enable`=0 and `timeout_err`=1.
  - `start` → SLOS1, clearing `timeout_err`.
  - `abort` → IDLE, clearing `timeout_err`.
- Timer:
  - Increments every cycle in SLOS1 and SLOS2.
  - When the timer equals TIMEOUT_CYCLES-1 and no phase exit occurs that cycle, the next state is ERROR.
- `start` is ignored in SLOS1, SLOS2 and DONE.
- Peer-detect inputs are sampled only on `slos_sent` cycles. A detect that rises between pulses takes effect at the next pulse.

## Timing
- Reset values: state IDLE, `gen_enable`=0, `gen_sel`=0, `busy`=0, `done`=0, `timeout_err`=0, counter=0, timer=0.
- Latency from `start` to `gen_enable`=1: one edge. `start` is sampled at edge k; `gen_enable` is high after edge k.
- A phase change takes effect the cycle after the qualifying `slos_sent` pulse.
- From the final qualifying SLOS2 pulse: `done` is high for the one cycle after the next edge, and `gen_enable` is low from that same edge.
- Simultaneous events:
  - `abort` beats every other condition, including `start` in IDLE and a phase exit.
  - A phase exit beats a timeout in the same cycle.
- `reset` mid-sequence: all outputs return to reset values immediately (asynchronously). `done` is not pulsed.
- An `abort` in SLOS1 or SLOS2 drops `gen_enable` after one edge. No `done` is pulsed and `timeout_err` does not change.

## Structure
- Package `slos_seq_pkg` holds:
  - the state enum and its 3-bit encodings;
  - the `GEN_SEL_SLOS1`=0 and `GEN_SEL_SLOS2`=1 constants.
- One natural sub-module, `slos_seq_timer`:
  - TMO_W counter with `clear`/`run` inputs;
  - `expired` output when count equals TIMEOUT_CYCLES-1.
- Everything else (FSM, round counter, output registers) lives in `slos_sequencer`.

## Test plan
- Nominal run (defaults, peer detects held at 1): `start`, then `slos_sent` pulses every 2048 cycles.
  - `gen_sel` goes 0→1 after the 2nd pulse.
  - `done` pulses after the 4th pulse, and `gen_enable` falls at the same time.
  - `busy` stays high throughout the sequence.
- Late peer: `peer_slos1_det`=0 for 5 pulses, then 1.
  - SLOS1 persists for 6 pulses.
  - Switch to SLOS2 after the 6th pulse.
- Timeout (TIMEOUT_CYCLES=100, no `slos_sent`):
  - ERROR at cycle 100 after entering SLOS1, with `timeout_err`=1 and `gen_enable`=0.
  - A subsequent `start` clears `timeout_err` and re-enters SLOS1.
- Collisions:
  - `abort` on a qualifying SLOS2 pulse → IDLE, no `done`.
  - Timer expiring on a qualifying SLOS1 pulse → SLOS2, no ERROR.
- Reset mid-SLOS2 and `start` during SLOS1:
  - Reset zeroes all outputs asynchronously.
  - A mid-sequence `start` causes no restart; counter and timer continue.
